// File: rtl/proc_io_bridge.sv
// proc_io_bridge: host<->processor word bridge with FWFT input FIFO and valid/ready output FIFO (IO_ERR_CNT_EN adds err_cnt)
module proc_io_bridge #(
    parameter int          DEPTH       = 8,
    parameter logic [15:0] DEFAULT_DIN = 16'h0000
) (
    input  logic                     clk,
    input  logic                     sys_rst_n,
    input  logic [15:0]              host_wr_data,
    input  logic                     host_wr_valid,
    output logic                     host_wr_ready,
    output logic [15:0]              proc_din,
    input  logic                     proc_rd_strobe,
    input  logic [15:0]              proc_dout,
    input  logic                     proc_wr_strobe,
    output logic [15:0]              host_rd_data,
    output logic                     host_rd_valid,
    input  logic                     host_rd_ready,
    output logic [$clog2(DEPTH):0]   in_count,
    output logic [$clog2(DEPTH):0]   out_count,
    input  logic                     err_clr,
    output logic                     underflow,
    output logic                     overflow
`ifdef IO_ERR_CNT_EN
    ,
    output logic [7:0]               err_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [15:0]   in_mem  [DEPTH];
    logic [15:0]   out_mem [DEPTH];
    logic [AW-1:0] in_wp, in_rp, out_wp, out_rp;
    logic          in_push, in_pop, out_push, out_pop, uf_ev, of_ev;

    // Handshakes, FWFT heads and error events, all from registered state
    always_comb begin
        host_wr_ready = in_count != FULL;
        host_rd_valid = out_count != '0;
        in_push       = host_wr_valid & host_wr_ready;
        in_pop        = proc_rd_strobe & (in_count != '0);
        uf_ev         = proc_rd_strobe & (in_count == '0);
        out_pop       = host_rd_valid & host_rd_ready;
        out_push      = proc_wr_strobe & ((out_count != FULL) | out_pop);
        of_ev         = proc_wr_strobe & (out_count == FULL) & ~out_pop;
        proc_din      = (in_count != '0) ? in_mem[in_rp] : DEFAULT_DIN;
        host_rd_data  = host_rd_valid ? out_mem[out_rp] : 16'h0000;
    end

    // Storage is unreset; stale entries are never visible because heads are gated by the counts
    always_ff @(posedge clk) begin
        if (in_push) in_mem[in_wp] <= host_wr_data;
        if (out_push) out_mem[out_wp] <= proc_dout;
    end

    // Pointers and occupancy for both FIFOs
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            in_wp     <= '0;
            in_rp     <= '0;
            in_count  <= '0;
            out_wp    <= '0;
            out_rp    <= '0;
            out_count <= '0;
        end else begin
            in_wp     <= in_wp + AW'(in_push);
            in_rp     <= in_rp + AW'(in_pop);
            in_count  <= in_count + CW'(in_push) - CW'(in_pop);
            out_wp    <= out_wp + AW'(out_push);
            out_rp    <= out_rp + AW'(out_pop);
            out_count <= out_count + CW'(out_push) - CW'(out_pop);
        end
    end

    // Sticky error flags; a new event outranks a same-cycle clear
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            underflow <= uf_ev | (underflow & ~err_clr);
            overflow  <= of_ev | (overflow & ~err_clr);
        end
    end

`ifdef IO_ERR_CNT_EN
    logic [8:0] err_sum;

    // Saturating event total; clear drops the old value but keeps this cycle's events
    always_comb begin
        err_sum = {1'b0, err_clr ? 8'h00 : err_cnt} + {8'h00, uf_ev} + {8'h00, of_ev};
    end

    // Event counter register
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) err_cnt <= 8'h00;
        else            err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
`endif
endmodule

// File: tb/tb_proc_io_bridge.sv
// tb_proc_io_bridge: scoreboard bench for proc_io_bridge (checks err_cnt when IO_ERR_CNT_EN is defined)
module tb_proc_io_bridge;
    localparam logic [15:0] DEF = 16'h0000;

    logic        clk = 0;
    logic        sys_rst_n = 0;
    logic [15:0] host_wr_data = 0;
    logic        host_wr_valid = 0;
    logic        host_wr_ready;
    logic [15:0] proc_din;
    logic        proc_rd_strobe = 0;
    logic [15:0] proc_dout = 0;
    logic        proc_wr_strobe = 0;
    logic [15:0] host_rd_data;
    logic        host_rd_valid;
    logic        host_rd_ready = 0;
    logic [3:0]  in_count, out_count;
    logic        err_clr = 0;
    logic        underflow, overflow;
`ifdef IO_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    int checks = 0;
    int failures = 0;
    logic [15:0] in_q[$];
    logic [15:0] out_q[$];

    proc_io_bridge #(.DEPTH(8), .DEFAULT_DIN(DEF)) dut (
        .clk(clk), .sys_rst_n(sys_rst_n),
        .host_wr_data(host_wr_data), .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
        .proc_din(proc_din), .proc_rd_strobe(proc_rd_strobe),
        .proc_dout(proc_dout), .proc_wr_strobe(proc_wr_strobe),
        .host_rd_data(host_rd_data), .host_rd_valid(host_rd_valid), .host_rd_ready(host_rd_ready),
        .in_count(in_count), .out_count(out_count),
        .err_clr(err_clr), .underflow(underflow), .overflow(overflow)
`ifdef IO_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_out(input string nm);
        logic [15:0] exp;
        host_rd_ready = 1;
        for (int k = 0; k < 16 && host_rd_valid === 1'b1; k++) begin
            exp = (out_q.size() != 0) ? out_q.pop_front() : 16'hxxxx;
            checks++; if (host_rd_data !== exp) begin failures++; $display("FAIL %s_drain[%0d] got=%h exp=%h", nm, k, host_rd_data, exp); end
            cyc();
        end
        host_rd_ready = 0;
        checks++; if (host_rd_valid !== 1'b0 || out_count !== 4'd0 || out_q.size() != 0) begin failures++; $display("FAIL %s_empty valid=%b count=%0d left=%0d exp valid=0 count=0 left=0", nm, host_rd_valid, out_count, out_q.size()); end
    endtask

    task automatic drain_in(input string nm);
        logic [15:0] exp;
        while (in_q.size() != 0) begin
            exp = in_q.pop_front();
            checks++; if (proc_din !== exp) begin failures++; $display("FAIL %s_din got=%h exp=%h", nm, proc_din, exp); end
            proc_rd_strobe = 1;
            cyc();
        end
        proc_rd_strobe = 0;
        checks++; if (proc_din !== DEF || in_count !== 4'd0) begin failures++; $display("FAIL %s_in_empty din=%h count=%0d exp din=%h count=0", nm, proc_din, in_count, DEF); end
    endtask

    task automatic test_reset();
        sys_rst_n = 0;
        repeat (5) @(posedge clk);
        #1 sys_rst_n = 1;
        cyc();
        checks++; if (host_wr_ready !== 1'b1) begin failures++; $display("FAIL rst_wr_ready got=%b exp=1", host_wr_ready); end
        checks++; if (proc_din !== DEF) begin failures++; $display("FAIL rst_proc_din got=%h exp=%h", proc_din, DEF); end
        checks++; if (host_rd_valid !== 1'b0 || host_rd_data !== 16'h0) begin failures++; $display("FAIL rst_rd got valid=%b data=%h exp 0/0000", host_rd_valid, host_rd_data); end
        checks++; if (in_count !== 4'd0 || out_count !== 4'd0) begin failures++; $display("FAIL rst_counts got=%0d/%0d exp=0/0", in_count, out_count); end
        checks++; if (underflow !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", underflow, overflow); end
    endtask

    task automatic test_fwft();
        logic [15:0] w [3] = '{16'hf3c0, 16'h0001, 16'h0002};
        for (int i = 0; i < 3; i++) begin
            host_wr_data = w[i]; host_wr_valid = 1; in_q.push_back(w[i]);
            cyc();
            if (i == 0) begin
                checks++; if (proc_din !== 16'hf3c0) begin failures++; $display("FAIL fwft_first got=%h exp=f3c0", proc_din); end
            end
        end
        host_wr_valid = 0;
        checks++; if (in_count !== 4'd3) begin failures++; $display("FAIL fwft_count got=%0d exp=3", in_count); end
        drain_in("fwft");
    endtask

    task automatic test_in_full();
        logic [15:0] exp;
        for (int i = 0; i < 8; i++) begin
            host_wr_data = 16'h0100 + 16'(i); host_wr_valid = 1; in_q.push_back(host_wr_data);
            cyc();
        end
        checks++; if (host_wr_ready !== 1'b0 || in_count !== 4'd8) begin failures++; $display("FAIL full_state ready=%b count=%0d exp ready=0 count=8", host_wr_ready, in_count); end
        host_wr_data = 16'h0109;
        cyc();
        checks++; if (in_count !== 4'd8) begin failures++; $display("FAIL full_hold got=%0d exp=8", in_count); end
        exp = in_q.pop_front();
        checks++; if (proc_din !== exp) begin failures++; $display("FAIL full_head got=%h exp=%h", proc_din, exp); end
        proc_rd_strobe = 1;
        cyc();
        proc_rd_strobe = 0;
        checks++; if (in_count !== 4'd7 || host_wr_ready !== 1'b1) begin failures++; $display("FAIL full_pop_push count=%0d ready=%b exp count=7 ready=1", in_count, host_wr_ready); end
        in_q.push_back(16'h0109);
        cyc();
        host_wr_valid = 0;
        checks++; if (in_count !== 4'd8) begin failures++; $display("FAIL full_ninth got=%0d exp=8", in_count); end
        drain_in("full");
    endtask

    task automatic test_underflow();
        proc_rd_strobe = 1;
        cyc();
        proc_rd_strobe = 0;
        checks++; if (underflow !== 1'b1 || in_count !== 4'd0 || proc_din !== DEF) begin failures++; $display("FAIL uf_set uf=%b count=%0d din=%h exp 1/0/%h", underflow, in_count, proc_din, DEF); end
`ifdef IO_ERR_CNT_EN
        checks++; if (err_cnt !== 8'd1) begin failures++; $display("FAIL uf_cnt got=%0d exp=1", err_cnt); end
`endif
        err_clr = 1;
        cyc();
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL uf_clr got=%b exp=0", underflow); end
`ifdef IO_ERR_CNT_EN
        checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL uf_cnt_clr got=%0d exp=0", err_cnt); end
`endif
        proc_rd_strobe = 1;
        cyc();
        proc_rd_strobe = 0;
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL uf_set_wins got=%b exp=1", underflow); end
`ifdef IO_ERR_CNT_EN
        checks++; if (err_cnt !== 8'd1) begin failures++; $display("FAIL uf_cnt_set_wins got=%0d exp=1", err_cnt); end
`endif
        cyc();
        err_clr = 0;
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL uf_clr2 got=%b exp=0", underflow); end
    endtask

    task automatic test_out_overflow();
        host_rd_ready = 0;
        for (int i = 0; i < 9; i++) begin
            proc_dout = 16'(i); proc_wr_strobe = 1;
            if (i < 8) out_q.push_back(proc_dout);
            cyc();
            if (i == 0) begin
                checks++; if (host_rd_valid !== 1'b1 || host_rd_data !== 16'h0) begin failures++; $display("FAIL ovf_first valid=%b data=%h exp 1/0000", host_rd_valid, host_rd_data); end
            end
        end
        proc_wr_strobe = 0;
        checks++; if (out_count !== 4'd8 || overflow !== 1'b1) begin failures++; $display("FAIL ovf_state count=%0d ovf=%b exp count=8 ovf=1", out_count, overflow); end
        drain_out("ovf");
        err_clr = 1;
        cyc();
        err_clr = 0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
    endtask

    task automatic test_out_full_pop();
        logic [15:0] exp;
        for (int i = 0; i < 8; i++) begin
            proc_dout = 16'h0200 + 16'(i); proc_wr_strobe = 1; out_q.push_back(proc_dout);
            cyc();
        end
        proc_dout = 16'hAAAA; host_rd_ready = 1;
        exp = out_q.pop_front();
        checks++; if (host_rd_data !== exp) begin failures++; $display("FAIL fp_head got=%h exp=%h", host_rd_data, exp); end
        out_q.push_back(16'hAAAA);
        cyc();
        proc_wr_strobe = 0; host_rd_ready = 0;
        checks++; if (overflow !== 1'b0 || out_count !== 4'd8) begin failures++; $display("FAIL fp_state ovf=%b count=%0d exp ovf=0 count=8", overflow, out_count); end
        drain_out("fp");
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            host_wr_valid = (i < 3); host_wr_data = 16'h0300 + 16'(i);
            proc_wr_strobe = 1; proc_dout = 16'h0400 + 16'(i);
            cyc();
        end
        host_wr_valid = 0; proc_wr_strobe = 0;
        checks++; if (in_count !== 4'd3 || out_count !== 4'd5) begin failures++; $display("FAIL ar_counts got=%0d/%0d exp=3/5", in_count, out_count); end
        #2 sys_rst_n = 0;
        #1;
        checks++; if (in_count !== 4'd0 || out_count !== 4'd0 || host_wr_ready !== 1'b1) begin failures++; $display("FAIL ar_imm_counts in=%0d out=%0d ready=%b exp 0/0/1", in_count, out_count, host_wr_ready); end
        checks++; if (proc_din !== DEF || host_rd_valid !== 1'b0 || host_rd_data !== 16'h0) begin failures++; $display("FAIL ar_imm_data din=%h valid=%b data=%h exp %h/0/0000", proc_din, host_rd_valid, host_rd_data, DEF); end
        #1 sys_rst_n = 1;
        cyc();
        checks++; if (in_count !== 4'd0 || out_count !== 4'd0 || underflow !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL ar_after in=%0d out=%0d flags=%b%b exp 0/0/00", in_count, out_count, underflow, overflow); end
    endtask

    initial begin
        test_reset();
        test_fwft();
        test_in_full();
        test_underflow();
        test_out_overflow();
        test_out_full_pop();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
